// File: rtl/mem_adapter_pkg.sv
// Shared types and defaults for the memory request adapter and its response FIFO.
package mem_adapter_pkg;

  localparam int DEF_RSP_DEPTH = 3;
  localparam int DEF_ID_WIDTH  = 4;

  // Widest tag the response entry can carry; narrower tags are zero-extended
  // into it and the unused upper bits are optimised away.
  localparam int ID_MAX = 16;

  typedef struct packed {
    logic [63:0]       rdata;
    logic [ID_MAX-1:0] id;
    logic              we;
  } rsp_entry_t;

  // Width of a counter that must hold the values 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// Synchronous response FIFO of rsp_entry_t with registered output and no bypass.
// Pointers wrap modulo DEPTH so any depth 2..8 is usable, not only powers of two.
module mem_rsp_fifo
  import mem_adapter_pkg::*;
#(
  parameter int DEPTH = DEF_RSP_DEPTH
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  rsp_entry_t                data_i,
  output rsp_entry_t                data_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [cnt_w(DEPTH)-1:0]   count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_w(DEPTH);

  rsp_entry_t    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push at full is only taken when a pop frees the slot in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_nxt(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_nxt(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry storage; contents are qualified by the count so they need no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_o && !pop_i));

endmodule

// File: rtl/mem_req_adapter.sv
// Adapts a valid/ready request stream onto a fixed-latency, never-stalling memory
// port and buffers the responses. Requests are admitted only while a response slot
// is guaranteed (FIFO entries plus the one request in flight), so the FIFO can
// never overflow and the memory never needs to be stalled.
module mem_req_adapter
  import mem_adapter_pkg::*;
#(
  parameter int RSP_DEPTH = DEF_RSP_DEPTH,
  parameter int ID_WIDTH  = DEF_ID_WIDTH   // must not exceed ID_MAX
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  // request side
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [63:0]         req_addr_i,
  input  logic                req_we_i,
  input  logic [7:0]          req_be_i,
  input  logic [63:0]         req_wdata_i,
  input  logic [ID_WIDTH-1:0] req_id_i,
  // memory port
  output logic [63:0]         mem_address_o,
  output logic                mem_data_req_o,
  output logic [7:0]          mem_data_be_o,
  output logic                mem_data_we_o,
  output logic [63:0]         mem_data_wdata_o,
  input  logic                mem_data_rvalid_i,
  input  logic [63:0]         mem_data_rdata_i,
  // response side
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [63:0]         rsp_rdata_o,
  output logic [ID_WIDTH-1:0] rsp_id_o,
  output logic                rsp_we_o,
  output logic                err_o
);

  localparam int CW = cnt_w(RSP_DEPTH);

  logic                inflight_q;
  logic [ID_WIDTH-1:0] infl_id_q;
  logic                infl_we_q;
  logic                err_q;
  logic                accept;
  logic                push;
  logic                pop;
  logic [CW-1:0]       fifo_cnt;
  logic [CW:0]         credit;
  logic                fifo_empty;
  logic                fifo_full_unused;
  logic                id_hi_unused;
  rsp_entry_t          push_ent;
  rsp_entry_t          pop_ent;

  // Credit is built from registered state only, so ready never depends on
  // req_valid_i or rsp_ready_i.
  assign credit      = {1'b0, fifo_cnt} + (CW+1)'(inflight_q);
  assign req_ready_o = (credit < (CW+1)'(RSP_DEPTH));
  assign accept      = req_valid_i & req_ready_o;

  // The memory grants every request, so the request is a straight pass-through.
  assign mem_data_req_o   = accept;
  assign mem_address_o    = req_addr_i;
  assign mem_data_be_o    = req_be_i;
  assign mem_data_we_o    = req_we_i;
  assign mem_data_wdata_o = req_wdata_i;

  // A response is only kept when it lines up with the request in flight.
  assign push = inflight_q & mem_data_rvalid_i;
  assign pop  = rsp_valid_o & rsp_ready_i;

  // Assemble the FIFO entry from returning data and the captured tag.
  always_comb begin
    push_ent                    = '0;
    push_ent.rdata              = mem_data_rdata_i;
    push_ent.id[ID_WIDTH-1:0]   = infl_id_q;
    push_ent.we                 = infl_we_q;
  end

  // In-flight tracker: holds {id, we} for exactly the cycle after acceptance.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      inflight_q <= 1'b0;
      infl_id_q  <= '0;
      infl_we_q  <= 1'b0;
    end else begin
      inflight_q <= accept;
      if (accept) begin
        infl_id_q <= req_id_i;
        infl_we_q <= req_we_i;
      end
    end
  end

  // Sticky protocol error: response without a request, or request without response.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if ((mem_data_rvalid_i & ~inflight_q) | (inflight_q & ~mem_data_rvalid_i)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  mem_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_ent),
    .data_o  (pop_ent),
    .full_o  (fifo_full_unused),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign rsp_valid_o  = ~fifo_empty;
  assign rsp_rdata_o  = pop_ent.rdata;
  assign rsp_id_o     = pop_ent.id[ID_WIDTH-1:0];
  assign rsp_we_o     = pop_ent.we;
  assign id_hi_unused = ^pop_ent.id;

  a_credit_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    credit <= (CW+1)'(RSP_DEPTH));

endmodule

// File: doc/mem_req_adapter.md
MEM_REQ_ADAPTER -- requirements
Module: mem_req_adapter

Interface
REQ-001 Parameter: RSP_DEPTH, 3, response buffer entries (legal 2..8; 3 gives one request per cycle sustained).
REQ-002 Parameter: ID_WIDTH, 4, width of the request tag echoed in each response.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  reset, synchronous, active-low.
REQ-005 req_valid_i  in  1  request valid.
REQ-006 req_ready_o  out  1  request accepted when valid and ready are both high.
REQ-007 req_addr_i  in  64  byte address.
REQ-008 req_we_i / req_be_i / req_wdata_i  in  1/8/64  write enable, byte enables, write data.
REQ-009 req_id_i  in  ID_WIDTH  request tag.
REQ-010 mem_address_o / mem_data_req_o / mem_data_be_o / mem_data_we_o / mem_data_wdata_o  out  64/1/8/1/64  memory port; the memory grants every request and never stalls.
REQ-011 mem_data_rvalid_i / mem_data_rdata_i  in  1/64  memory response, exactly one cycle after mem_data_req_o.
REQ-012 rsp_valid_o / rsp_ready_i  out/in  1/1  response handshake.
REQ-013 rsp_rdata_o / rsp_id_o / rsp_we_o  out  64/ID_WIDTH/1  response payload; rsp_rdata_o is undefined for writes.
REQ-014 err_o  out  1  sticky protocol-error flag.

Function
REQ-015 Credit count = FIFO occupancy + in-flight flag (0/1); req_ready_o SHALL be high iff credit count < RSP_DEPTH.
REQ-016 req_ready_o SHALL NOT depend combinationally on req_valid_i or rsp_ready_i.
REQ-017 mem_data_req_o SHALL equal req_valid_i AND req_ready_o.
REQ-018 Address, be, we and wdata SHALL pass combinationally from req_* to mem_* outputs.
REQ-019 On acceptance, the in-flight register SHALL capture {id, we} and set in-flight for exactly the next cycle.
REQ-020 When mem_data_rvalid_i is high and in-flight is set, {rdata, id, we} SHALL be pushed into the FIFO in that cycle.
REQ-021 Latency: a request accepted in cycle T SHALL have rsp_valid_o high from cycle T+2, since the FIFO output is registered and there is no bypass.
REQ-022 Responses SHALL leave in acceptance order; rsp_* SHALL hold stable while rsp_valid_o is high and rsp_ready_i is low.
REQ-023 A push and a pop in the same cycle SHALL leave occupancy unchanged; this is legal at full occupancy.
REQ-024 FIFO pointers SHALL wrap modulo RSP_DEPTH; overflow is impossible by construction (REQ-015).
REQ-025 mem_data_rvalid_i high with in-flight clear SHALL set err_o, and the data SHALL be dropped.
REQ-026 In-flight set with mem_data_rvalid_i low SHALL set err_o, and the response SHALL be lost; in-flight SHALL clear regardless.
REQ-027 err_o, once set, SHALL remain set until reset.

Reset
REQ-028 While rst_ni is low at a clock edge: FIFO emptied, in-flight cleared, err_o = 0.
REQ-029 In reset, rsp_valid_o SHALL be 0; req_ready_o follows REQ-015 and equals 1 because the credit count is 0.
REQ-030 A reset asserted mid-transaction SHALL discard all buffered and in-flight responses; no stale response SHALL appear after release.

Structure
REQ-031 Shared package mem_adapter_pkg SHALL hold the response-entry struct {rdata[63:0], id, we} and the default RSP_DEPTH and ID_WIDTH constants.
REQ-032 One sub-module, mem_rsp_fifo: a synchronous FIFO of the entry struct with push, pop, full, empty and a count output.

Verification
REQ-033 Single read: addr 0x8000_0010, id 5, rsp_ready_i = 1 -> mem_data_req_o in cycle T; rsp_valid_o in T+2 with rsp_id_o = 5 and memory data.
REQ-034 Back-to-back reads, 10 requests, ids 0..9, rsp_ready_i = 1 -> req_ready_o stays high; 10 responses in order; one response per cycle.
REQ-035 Backpressure: rsp_ready_i = 0, RSP_DEPTH = 3 -> exactly 3 requests accepted, then req_ready_o = 0; raising rsp_ready_i drains ids in order and restores req_ready_o.
REQ-036 Full-FIFO simultaneous push and pop -> occupancy constant; no response lost or duplicated.
REQ-037 Spurious mem_data_rvalid_i with nothing in flight -> err_o = 1 next cycle; FIFO unchanged.
REQ-038 Reset asserted with 2 buffered responses and 1 in flight -> after release, rsp_valid_o = 0, req_ready_o = 1, err_o = 0.
